// File: rtl/btn_conditioner.sv
// Three-button input conditioner: 2-flop synchroniser, per-button debounce,
// registered level, press/release pulses and a priority-encoded press code.
module btn_conditioner #(
    parameter int unsigned DB_CYCLES = 1_000_000,
    parameter int unsigned CNT_W     = $clog2(DB_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:1] btn_raw,
    output logic [3:1] btn_level,
    output logic [3:1] btn_press,
    output logic [3:1] btn_release,
    output logic [1:0] press_code
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

    logic [3:1]            sync1_q, sync1_d;
    logic [3:1]            sync2_q, sync2_d;
    logic [3:1][CNT_W-1:0] cnt_q, cnt_d;
    logic [3:1]            level_q, level_d;
    logic [3:1]            press_q, press_d;
    logic [3:1]            release_q, release_d;
    logic [1:0]            code_q, code_d;

    // Debounce: a differing synchronised value must persist DB_CYCLES cycles.
    always_comb begin
        sync1_d   = btn_raw;
        sync2_d   = sync1_q;
        cnt_d     = cnt_q;
        level_d   = level_q;
        press_d   = '0;
        release_d = '0;
        code_d    = 2'd0;

        for (int i = 1; i <= 3; i++) begin
            if (sync2_q[i] == level_q[i]) begin
                cnt_d[i] = '0;
            end else if (cnt_q[i] == CNT_LAST) begin
                cnt_d[i]     = '0;
                level_d[i]   = sync2_q[i];
                press_d[i]   = sync2_q[i];
                release_d[i] = ~sync2_q[i];
            end else begin
                cnt_d[i] = cnt_q[i] + CNT_W'(1);
            end
        end

        // Lowest button index wins when several are accepted together.
        if (press_d[1]) begin
            code_d = 2'd1;
        end else if (press_d[2]) begin
            code_d = 2'd2;
        end else if (press_d[3]) begin
            code_d = 2'd3;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            cnt_q     <= '0;
            level_q   <= '0;
            press_q   <= '0;
            release_q <= '0;
            code_q    <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            cnt_q     <= cnt_d;
            level_q   <= level_d;
            press_q   <= press_d;
            release_q <= release_d;
            code_q    <= code_d;
        end
    end

    assign btn_level   = level_q;
    assign btn_press   = press_q;
    assign btn_release = release_q;
    assign press_code  = code_q;

endmodule

// File: tb/tb_btn_conditioner.sv
// Self-checking bench for btn_conditioner with DB_CYCLES=4: per-cycle vector
// table fed through a scoreboard queue, plus hand-written reset sequences.
module tb_btn_conditioner;

    localparam int unsigned DB = 4;

    typedef struct packed {
        logic [3:1] lvl;
        logic [3:1] prs;
        logic [3:1] rel;
        logic [1:0] code;
    } exp_t;

    typedef struct packed {
        logic [3:1] raw;
        exp_t       exp;
    } row_t;

    logic       clk;
    logic       rst_n;
    logic [3:1] btn_raw;
    logic [3:1] btn_level;
    logic [3:1] btn_press;
    logic [3:1] btn_release;
    logic [1:0] press_code;

    row_t tbl[$];
    exp_t sb[$];
    int   n_checks;
    int   n_errors;
    int   row_idx;

    btn_conditioner #(.DB_CYCLES(DB)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .btn_raw     (btn_raw),
        .btn_level   (btn_level),
        .btn_press   (btn_press),
        .btn_release (btn_release),
        .press_code  (press_code)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, got timeout, expected $finish");
        $fatal(1, "watchdog expired");
    end

    function automatic exp_t dut_out();
        exp_t o;
        o.lvl  = btn_level;
        o.prs  = btn_press;
        o.rel  = btn_release;
        o.code = press_code;
        return o;
    endfunction

    task automatic check(input string name, input exp_t got, input exp_t want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got lvl=%b prs=%b rel=%b code=%0d, expected lvl=%b prs=%b rel=%b code=%0d",
                     name, got.lvl, got.prs, got.rel, got.code,
                     want.lvl, want.prs, want.rel, want.code);
        end
    endtask

    // Append n identical per-cycle rows (input, outputs expected after that edge).
    task automatic vec(input logic [3:1] raw, input logic [3:1] lvl, input logic [3:1] prs,
                       input logic [3:1] rel, input logic [1:0] code, input int n);
        row_t r;
        r.raw      = raw;
        r.exp.lvl  = lvl;
        r.exp.prs  = prs;
        r.exp.rel  = rel;
        r.exp.code = code;
        for (int j = 0; j < n; j++) tbl.push_back(r);
    endtask

    // Drive each row on the falling edge, score it one sample after the rising edge.
    task automatic run_tbl();
        row_t r;
        exp_t e;
        while (tbl.size() > 0) begin
            r = tbl.pop_front();
            @(negedge clk);
            btn_raw = r.raw;
            sb.push_back(r.exp);
            @(posedge clk);
            #1;
            e = sb.pop_front();
            row_idx++;
            check($sformatf("row%0d", row_idx), dut_out(), e);
        end
    endtask

    exp_t zero;

    initial begin
        n_checks = 0;
        n_errors = 0;
        row_idx  = 0;
        zero     = '0;
        rst_n    = 1'b0;
        btn_raw  = 3'b111;

        #1;
        check("reset_async_t0", dut_out(), zero);
        for (int j = 0; j < 3; j++) begin
            @(posedge clk);
            #1;
            check($sformatf("reset_hold%0d", j), dut_out(), zero);
        end
        rst_n = 1'b1;

        // Buttons held through reset: fresh press accepted at edge 6.
        vec(3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b111, 3'b111, 3'b111, 3'b000, 2'd1, 1);
        vec(3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2);
        // Release all.
        vec(3'b000, 3'b111, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b000, 3'b000, 3'b000, 3'b111, 2'd0, 1);
        vec(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2);
        // Clean press of btn2, then long hold without further pulses.
        vec(3'b010, 3'b000, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b010, 3'b010, 3'b010, 3'b000, 2'd2, 1);
        vec(3'b010, 3'b010, 3'b000, 3'b000, 2'd0, 6);
        // btn1 bounce: high 3, low 1, then steady high.
        vec(3'b011, 3'b010, 3'b000, 3'b000, 2'd0, 3);
        vec(3'b010, 3'b010, 3'b000, 3'b000, 2'd0, 1);
        vec(3'b011, 3'b010, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b011, 3'b011, 3'b001, 3'b000, 2'd1, 1);
        vec(3'b011, 3'b011, 3'b000, 3'b000, 2'd0, 3);
        // Release btn1 and btn2 together.
        vec(3'b000, 3'b011, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b000, 3'b000, 3'b000, 3'b011, 2'd0, 1);
        vec(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2);
        // Simultaneous press btn3+btn2: code reports btn2.
        vec(3'b110, 3'b000, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b110, 3'b110, 3'b110, 3'b000, 2'd2, 1);
        vec(3'b110, 3'b110, 3'b000, 3'b000, 2'd0, 3);
        // Release btn3 only.
        vec(3'b010, 3'b110, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b010, 3'b010, 3'b000, 3'b100, 2'd0, 1);
        vec(3'b010, 3'b010, 3'b000, 3'b000, 2'd0, 2);
        // Press btn3 alone: code 3.
        vec(3'b110, 3'b010, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b110, 3'b110, 3'b100, 3'b000, 2'd3, 1);
        vec(3'b110, 3'b110, 3'b000, 3'b000, 2'd0, 2);
        // btn3 release glitch of DB-1 cycles is rejected.
        vec(3'b010, 3'b110, 3'b000, 3'b000, 2'd0, 3);
        vec(3'b110, 3'b110, 3'b000, 3'b000, 2'd0, 6);
        // btn3 release of exactly DB cycles is accepted, then re-pressed.
        vec(3'b010, 3'b110, 3'b000, 3'b000, 2'd0, 4);
        vec(3'b110, 3'b110, 3'b000, 3'b000, 2'd0, 1);
        vec(3'b110, 3'b010, 3'b000, 3'b100, 2'd0, 1);
        vec(3'b110, 3'b010, 3'b000, 3'b000, 2'd0, 3);
        vec(3'b110, 3'b110, 3'b100, 3'b000, 2'd3, 1);
        vec(3'b110, 3'b110, 3'b000, 3'b000, 2'd0, 2);
        // Start qualifying btn1; after 4 edges its counter sits at 2.
        vec(3'b111, 3'b110, 3'b000, 3'b000, 2'd0, 4);
        run_tbl();

        // Asynchronous reset between edges clears outputs with no clock edge.
        #2;
        rst_n = 1'b0;
        #1;
        check("async_reset_midcount", dut_out(), zero);
        check("sb_empty", exp_t'(sb.size()), zero);
        @(posedge clk);
        #1;
        check("async_reset_held", dut_out(), zero);
        rst_n = 1'b1;

        // Full fresh qualification required for all held buttons.
        vec(3'b111, 3'b000, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b111, 3'b111, 3'b111, 3'b000, 2'd1, 1);
        vec(3'b111, 3'b111, 3'b000, 3'b000, 2'd0, 2);
        vec(3'b000, 3'b111, 3'b000, 3'b000, 2'd0, 5);
        vec(3'b000, 3'b000, 3'b000, 3'b111, 2'd0, 1);
        vec(3'b000, 3'b000, 3'b000, 3'b000, 2'd0, 2);
        run_tbl();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
